// File: rtl/c3aibadapt_rxdp_pkg.sv
// Shared RX datapath definitions: map-mode codes, word-marker FSM encoding,
// marker bit positions and the RX FIFO word layout.
package c3aibadapt_rxdp_pkg;

   localparam int unsigned MODE_W = 3;
   localparam int unsigned WORD_W = 78;
   localparam int unsigned PMA_W  = 40;
   localparam int unsigned FIFO_W = 80;

   localparam logic [MODE_W-1:0] RX_EHIP_MODE   = 3'd1;
   localparam logic [MODE_W-1:0] RX_ELANE_MODE  = 3'd2;
   localparam logic [MODE_W-1:0] RX_RSFEC_MODE  = 3'd3;
   localparam logic [MODE_W-1:0] RX_PMADIR_MODE = 3'd4;

   localparam int unsigned WM_HI_BIT = 79;
   localparam int unsigned WM_LO_BIT = 39;

   typedef enum logic [1:0] {
      WM_IDLE = 2'd0,
      WM_FILL = 2'd1,
      WM_RUN  = 2'd2
   } wm_state_e;

   // FIFO write word for the parallel (mapped) modes
   typedef struct packed {
      logic        wm_hi;
      logic [38:0] d_hi;
      logic        wm_lo;
      logic [38:0] d_lo;
   } fifo_word_t;

   function automatic logic mode_valid(input logic [MODE_W-1:0] m);
      return (m == RX_EHIP_MODE) || (m == RX_ELANE_MODE) ||
             (m == RX_RSFEC_MODE) || (m == RX_PMADIR_MODE);
   endfunction

   function automatic fifo_word_t pack_parallel(input logic [WORD_W-1:0] d,
                                                input logic wm_en);
      fifo_word_t w;
      w.wm_hi = wm_en;
      w.d_hi  = d[77:39];
      w.wm_lo = 1'b0;
      w.d_lo  = d[38:0];
      return w;
   endfunction

endpackage

// File: rtl/c3aibadapt_rxdp_wm_align.sv
// 2:1 PMA-direct beat packer: phase flop, held low half and marker-slip detection.
module c3aibadapt_rxdp_wm_align
   import c3aibadapt_rxdp_pkg::*;
(
   input  logic                 rx_clock_fifo_wr_clk,
   input  logic                 rx_reset_fifo_wr_rst,
   input  logic                 flush,
   input  logic                 advance,
   input  logic                 check,
   input  logic [PMA_W-1:0]     beat,
   output logic                 phase,
   output logic [PMA_W-1:0]     held,
   output logic                 slip_c,
   output logic                 wr_c,
   output logic [FIFO_W-1:0]    pair_c
);

   // A marker seen where a low half is expected means we are one beat off
   assign slip_c = advance && check && !phase && beat[WM_LO_BIT];
   assign wr_c   = advance && phase;
   assign pair_c = {beat, held};

   always_ff @(posedge rx_clock_fifo_wr_clk) begin
      if (rx_reset_fifo_wr_rst) begin
         phase <= 1'b0;
         held  <= '0;
      end else if (flush) begin
         phase <= 1'b0;
      end else if (advance && !slip_c) begin
         phase <= ~phase;
         if (!phase) held <= beat;
      end
   end

endmodule

// File: rtl/c3aibadapt_rxdp_wm_pack.sv
// RX FIFO write-word builder: word-marker insertion, PMA-direct 2:1 packing,
// start-up FILL delay and flush on map-mode reconfiguration.
module c3aibadapt_rxdp_wm_pack
   import c3aibadapt_rxdp_pkg::*;
#(
   parameter int unsigned START_DLY = 4,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                 rx_clock_fifo_wr_clk,
   input  logic                 rx_reset_fifo_wr_rst,
   input  logic [MODE_W-1:0]    r_dp_map_mode,
   input  logic                 r_wm_en,
   input  logic                 r_double_write,
   input  logic [WORD_W-1:0]    word_marker_data,
   input  logic [PMA_W-1:0]     pma_direct_data,
   output logic [FIFO_W-1:0]    fifo_wr_data,
   output logic                 fifo_wr_en,
   output logic [1:0]           wm_state,
   output logic                 wm_slip
);

   wm_state_e           state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MODE_W-1:0]   mode_q;

   logic                mode_ok_c;
   logic                pma_c;
   logic                dw_c;
   logic                run_c;
   logic                advance_c;
   logic                flush_c;
   logic                check_c;
   logic                wr_en_c;
   logic [FIFO_W-1:0]   data_c;

   logic                phase;
   logic [PMA_W-1:0]    held;
   logic                slip_c;
   logic                pair_wr_c;
   logic [FIFO_W-1:0]   pair_c;

   // Live mode must be legal and unchanged since last cycle to make progress
   assign mode_ok_c = mode_valid(r_dp_map_mode) && (r_dp_map_mode == mode_q);
   assign pma_c     = (r_dp_map_mode == RX_PMADIR_MODE);
   assign dw_c      = pma_c && r_double_write;
   assign run_c     = mode_ok_c && (state_q == WM_RUN);
   assign advance_c = mode_ok_c && (state_q != WM_IDLE) && dw_c;
   assign flush_c   = !mode_ok_c || (state_q == WM_IDLE);
   assign check_c   = (state_q == WM_RUN) && r_wm_en;

   always_ff @(posedge rx_clock_fifo_wr_clk) begin
      if (rx_reset_fifo_wr_rst) begin
         state_q <= WM_IDLE;
         cnt_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= r_dp_map_mode;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!mode_ok_c) begin
         state_d = WM_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            WM_IDLE: begin
               state_d = WM_FILL;
               cnt_d   = '0;
            end
            WM_FILL: begin
               if (cnt_q == CNT_W'(START_DLY - 1)) begin
                  state_d = WM_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WM_RUN:  state_d = WM_RUN;
            default: begin
               state_d = WM_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   c3aibadapt_rxdp_wm_align u_align (
      .rx_clock_fifo_wr_clk (rx_clock_fifo_wr_clk),
      .rx_reset_fifo_wr_rst (rx_reset_fifo_wr_rst),
      .flush                (flush_c),
      .advance              (advance_c),
      .check                (check_c),
      .beat                 (pma_direct_data),
      .phase                (phase),
      .held                 (held),
      .slip_c               (slip_c),
      .wr_c                 (pair_wr_c),
      .pair_c               (pair_c)
   );

   always_comb begin
      data_c  = pack_parallel(word_marker_data, r_wm_en);
      wr_en_c = run_c;
      if (dw_c) begin
         data_c  = pair_c;
         wr_en_c = run_c && pair_wr_c;
      end else if (pma_c) begin
         data_c  = {{(FIFO_W-PMA_W){1'b0}}, pma_direct_data};
      end
   end

   // Write data only moves on a write; idle cycles hold the last word
   always_ff @(posedge rx_clock_fifo_wr_clk) begin
      if (rx_reset_fifo_wr_rst) begin
         fifo_wr_data <= '0;
         fifo_wr_en   <= 1'b0;
         wm_slip      <= 1'b0;
      end else begin
         fifo_wr_en <= wr_en_c;
         wm_slip    <= slip_c;
         if (wr_en_c) fifo_wr_data <= data_c;
      end
   end

   assign wm_state = state_q;

endmodule

// File: tb/tb_c3aibadapt_rxdp_wm_pack.sv
// Randomized directed bench for c3aibadapt_rxdp_wm_pack against a cycle-level
// behavioural model (stable-mode run length plus a beat queue for packing).
module tb_c3aibadapt_rxdp_wm_pack;
   import c3aibadapt_rxdp_pkg::*;

   localparam int unsigned DLY = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  mode;
   logic        wm_en;
   logic        dw;
   logic [77:0] wdata;
   logic [39:0] pdata;
   logic [79:0] fifo_wr_data;
   logic        fifo_wr_en;
   logic [1:0]  wm_state;
   logic        wm_slip;

   int checks   = 0;
   int failures = 0;

   int          run_len;
   logic [2:0]  prev_mode;
   logic [39:0] q[$];
   logic [79:0] exp_data;
   logic        exp_en;
   logic        exp_slip;
   logic [1:0]  exp_state;
   logic        chk_data;

   always #5 clk = ~clk;

   c3aibadapt_rxdp_wm_pack #(.START_DLY(DLY), .CNT_W(4)) dut (
      .rx_clock_fifo_wr_clk (clk),
      .rx_reset_fifo_wr_rst (rst),
      .r_dp_map_mode        (mode),
      .r_wm_en              (wm_en),
      .r_double_write       (dw),
      .word_marker_data     (wdata),
      .pma_direct_data      (pdata),
      .fifo_wr_data         (fifo_wr_data),
      .fifo_wr_en           (fifo_wr_en),
      .wm_state             (wm_state),
      .wm_slip              (wm_slip)
   );

   function automatic logic [1:0] state_of(input int n);
      if (n == 0) return 2'd0;
      if (n <= int'(DLY)) return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [39:0] rand_beat(input logic marker);
      logic [39:0] b;
      b = 40'({$urandom(), $urandom()});
      b[39] = marker;
      return b;
   endfunction

   task automatic compare(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour for the coming clock edge, from current inputs
   task automatic model_edge();
      logic [1:0]  cur;
      logic        ok;
      logic [79:0] par;
      exp_en   = 1'b0;
      exp_slip = 1'b0;
      chk_data = 1'b0;
      if (rst) begin
         run_len   = 0;
         prev_mode = 3'd0;
         q.delete();
         exp_data  = '0;
         exp_state = 2'd0;
         chk_data  = 1'b1;
         return;
      end
      cur = state_of(run_len);
      ok  = (mode >= 3'd1) && (mode <= 3'd4) && (mode == prev_mode);
      if (!ok || cur == 2'd0) begin
         q.delete();
      end else if (mode == 3'd4 && dw) begin
         if (cur == 2'd2 && wm_en && q.size() == 0 && pdata[39]) begin
            exp_slip = 1'b1;
         end else begin
            q.push_back(pdata);
            if (q.size() == 2) begin
               if (cur == 2'd2) begin
                  exp_en   = 1'b1;
                  exp_data = {q[1], q[0]};
               end
               q.delete();
            end
         end
      end else if (cur == 2'd2) begin
         exp_en = 1'b1;
         if (mode == 3'd4) begin
            exp_data = {40'd0, pdata};
         end else begin
            par      = '0;
            par[WM_HI_BIT] = wm_en;
            par[78:40] = wdata[77:39];
            par[38:0]  = wdata[38:0];
            exp_data = par;
         end
      end
      prev_mode = mode;
      run_len   = ok ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
      exp_state = state_of(run_len);
      chk_data  = exp_en;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare("wm_state", 80'(wm_state), 80'(exp_state));
      compare("fifo_wr_en", 80'(fifo_wr_en), 80'(exp_en));
      compare("wm_slip", 80'(wm_slip), 80'(exp_slip));
      if (chk_data) compare("fifo_wr_data", fifo_wr_data, exp_data);
   endtask

   task automatic aligned_step();
      pdata = rand_beat(q.size() == 1);
      step();
   endtask

   initial begin
      logic [77:0] pat;
      pat = {39{2'b10}};
      run_len = 0; prev_mode = 3'd0; exp_data = '0;
      rst = 1'b1; mode = 3'd1; wm_en = 1'b1; dw = 1'b0; wdata = pat; pdata = '0;
      @(negedge clk);
      step(); step();
      rst = 1'b0;

      // EHIP with markers: IDLE, 4 FILL, RUN, writes one cycle later
      for (int i = 0; i < 10; i++) step();
      for (int i = 0; i < 6; i++) begin
         wdata = 78'({$urandom(), $urandom(), $urandom()});
         step();
      end

      // RSFEC, no markers, walking one across the mapped payload
      mode = 3'd3; wm_en = 1'b0;
      for (int i = 0; i < 6; i++) step();
      for (int i = 0; i < 78; i++) begin
         wdata = '0;
         wdata[i] = 1'b1;
         step();
      end

      // EHIP then mid-run switch to ELANE
      mode = 3'd1; wm_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wdata = 78'({$urandom(), $urandom(), $urandom()});
         step();
      end
      mode = 3'd2;
      for (int i = 0; i < 10; i++) begin
         wdata = 78'({$urandom(), $urandom(), $urandom()});
         step();
      end

      // PMA-direct double write, aligned markers
      mode = 3'd4; dw = 1'b1; wm_en = 1'b1;
      for (int i = 0; i < 16; i++) aligned_step();
      for (int i = 0; i < 4 && q.size() != 0; i++) aligned_step();
      pdata = rand_beat(1'b1);
      step();
      for (int i = 0; i < 8; i++) aligned_step();
      // Stuck marker: continuous slips, no writes
      for (int i = 0; i < 6; i++) begin
         pdata = rand_beat(1'b1);
         step();
      end
      for (int i = 0; i < 8; i++) aligned_step();

      // PMA-direct single write
      dw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pdata = rand_beat(1'($urandom_range(0, 1)));
         step();
      end

      // Reset with a half-packed word held
      dw = 1'b1;
      for (int i = 0; i < 4 && q.size() != 1; i++) aligned_step();
      pdata = rand_beat(1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 14; i++) aligned_step();

      // Double write without alignment checking
      wm_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         pdata = rand_beat(1'($urandom_range(0, 1)));
         step();
      end

      // Invalid modes hold IDLE, then recover
      mode = 3'd0; for (int i = 0; i < 3; i++) step();
      mode = 3'd5; for (int i = 0; i < 3; i++) step();
      mode = 3'd7; for (int i = 0; i < 3; i++) step();
      mode = 3'd4; dw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pdata = rand_beat(1'($urandom_range(0, 1)));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
